// File: rtl/demux4_burst_sched_if.sv
// Bundles the producer and consumer signals of the 4-way burst scheduler.
//   master : drives in_valid/in_data/out_ready and observes everything else
//   slave  : the scheduler side
// Signals:
//   in_valid, in_ready, in_data      producer handshake and beat
//   out_ready[3:0], out_valid[3:0]   per-channel consumer handshake
//   y0..y3                           per-channel data (zero when that channel is not valid)
//   sel, busy, burst_done, burst_abort  status
interface demux4_burst_sched_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [3:0]   out_ready;
  logic [3:0]   out_valid;
  logic [W-1:0] y0;
  logic [W-1:0] y1;
  logic [W-1:0] y2;
  logic [W-1:0] y3;
  logic [1:0]   sel;
  logic         busy;
  logic         burst_done;
  logic         burst_abort;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, y0, y1, y2, y3, sel, busy, burst_done, burst_abort
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, y0, y1, y2, y3, sel, busy, burst_done, burst_abort
  );
endinterface

// File: rtl/demux4_burst_sched.sv
// Round-robin burst scheduler steering one input stream to four channels.
// Bursts of BURST beats rotate over channels 0..3, skipping channels that are
// not ready; a burst stalled for STALL_MAX consecutive cycles is abandoned.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    demux4_burst_sched_if.slave (handshakes, steered data, status)
module demux4_burst_sched #(
  parameter int unsigned W         = 8,
  parameter int unsigned BURST     = 4,
  parameter int unsigned STALL_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux4_burst_sched_if.slave   bus
);

  localparam int unsigned CNT_W   = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned STALL_W = (STALL_MAX > 1) ? $clog2(STALL_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(BURST - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEEK = 2'd1;
  localparam logic [1:0] XFER = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               done_q, done_d;
  logic               abort_q, abort_d;

  logic               xfer_ok_c;
  logic               txn_c;
  logic [3:0]         out_valid_c;
  logic [W-1:0]       data_c;

  // Steering: the granted channel sees the beat only while it can take it.
  assign xfer_ok_c = (state_q == XFER) & bus.out_ready[sel_q];
  assign txn_c     = xfer_ok_c & bus.in_valid;
  assign data_c    = bus.in_data;

  always_comb begin
    out_valid_c = 4'b0000;
    if (txn_c) out_valid_c[sel_q] = 1'b1;
  end

  assign bus.in_ready    = xfer_ok_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.y0          = out_valid_c[0] ? data_c : '0;
  assign bus.y1          = out_valid_c[1] ? data_c : '0;
  assign bus.y2          = out_valid_c[2] ? data_c : '0;
  assign bus.y3          = out_valid_c[3] ? data_c : '0;
  assign bus.sel         = sel_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.burst_done  = done_q;
  assign bus.burst_abort = abort_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      stall_q <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next-state: seek a ready channel, move a burst, abort on a long stall.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = SEEK;
      end
      SEEK: begin
        if (bus.out_ready[ptr_q]) begin
          state_d = XFER;
          sel_d   = ptr_q;
          cnt_d   = '0;
          stall_d = '0;
        end else begin
          ptr_d = ptr_q + 2'd1;
        end
      end
      XFER: begin
        if (txn_c) begin
          stall_d = '0;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (bus.in_valid) begin
          // Beat offered but channel not ready; an idle producer is not a stall.
          if (stall_q == STALL_LAST) begin
            state_d = SEEK;
            ptr_d   = sel_q + 2'd1;
            abort_d = 1'b1;
            cnt_d   = '0;
            stall_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demux4_burst_sched.sv
// Directed bench for demux4_burst_sched: a vector table covering rotation,
// channel skipping and producer gaps, then hand sequences for async reset
// mid-burst and a stall abort.
module tb_demux4_burst_sched;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       ir;
    logic [3:0] ov;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic       abort;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  demux4_burst_sched_if #(.W(8)) bus ();

  demux4_burst_sched #(.W(8), .BURST(4), .STALL_MAX(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [7:0] d, logic [3:0] ordy, logic ir,
                              logic [3:0] ov, logic [1:0] sel, logic busy,
                              logic done, logic abort);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.ir = ir; v.ov = ov;
    v.sel = sel; v.busy = busy; v.done = done; v.abort = abort;
    return v;
  endfunction

  function automatic void add(logic iv, logic [7:0] d, logic [3:0] ordy, logic ir,
                              logic [3:0] ov, logic [1:0] sel, logic busy,
                              logic done, logic abort);
    tbl.push_back(mk(iv, d, ordy, ir, ov, sel, busy, done, abort));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".in_ready"},    32'(bus.in_ready),    32'(v.ir));
    chk({tag, ".out_valid"},   32'(bus.out_valid),   32'(v.ov));
    chk({tag, ".y0"},          32'(bus.y0),          v.ov[0] ? 32'(v.d) : 32'd0);
    chk({tag, ".y1"},          32'(bus.y1),          v.ov[1] ? 32'(v.d) : 32'd0);
    chk({tag, ".y2"},          32'(bus.y2),          v.ov[2] ? 32'(v.d) : 32'd0);
    chk({tag, ".y3"},          32'(bus.y3),          v.ov[3] ? 32'(v.d) : 32'd0);
    chk({tag, ".sel"},         32'(bus.sel),         32'(v.sel));
    chk({tag, ".busy"},        32'(bus.busy),        32'(v.busy));
    chk({tag, ".burst_done"},  32'(bus.burst_done),  32'(v.done));
    chk({tag, ".burst_abort"}, 32'(bus.burst_abort), 32'(v.abort));
  endtask

  // Called 1 time unit after a rising edge: drive, check mid-cycle, advance.
  task automatic apply(input vec_t v, input string tag);
    bus.in_valid  = v.iv;
    bus.in_data   = v.d;
    bus.out_ready = v.ordy;
    #1;
    chk_outs(tag, v);
    @(posedge clk);
    #1;
  endtask

  // Every cycle: at most one channel valid, unselected channels carry zero.
  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (!$onehot0(bus.out_valid) ||
          (!bus.out_valid[0] && bus.y0 != 8'd0) || (!bus.out_valid[1] && bus.y1 != 8'd0) ||
          (!bus.out_valid[2] && bus.y2 != 8'd0) || (!bus.out_valid[3] && bus.y3 != 8'd0) ||
          (bus.burst_done && bus.burst_abort)) begin
        n_fail++;
        $display("FAIL isolation @%0t: out_valid=%b y=%h/%h/%h/%h done=%b abort=%b required one-hot0, idle y=0, not both pulses",
                 $time, bus.out_valid, bus.y0, bus.y1, bus.y2, bus.y3,
                 bus.burst_done, bus.burst_abort);
      end
    end
  end

  initial begin
    logic [1:0] ps;

    // Rotation: all channels ready, in_valid held, data 0x01..0x10.
    for (int b = 0; b < 4; b++) begin
      ps = (b == 0) ? 2'd0 : 2'(b - 1);
      add(1'b1, 8'(4*b + 1), 4'hF, 1'b0, 4'h0, ps, 1'b0, b > 0, 1'b0);  // IDLE
      add(1'b1, 8'(4*b + 1), 4'hF, 1'b0, 4'h0, ps, 1'b1, 1'b0, 1'b0);   // SEEK
      for (int k = 0; k < 4; k++)
        add(1'b1, 8'(4*b + 1 + k), 4'hF, 1'b1, 4'(1 << b), 2'(b), 1'b1, 1'b0, 1'b0);
    end
    add(1'b0, 8'h00, 4'hF, 1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 1'b0);

    // Skip: out_ready=1010 from ptr=0 -> ch1, then ch2 skipped -> ch3.
    add(1'b1, 8'h20, 4'hA, 1'b0, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0);  // IDLE
    add(1'b1, 8'h20, 4'hA, 1'b0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0);  // SEEK ch0 not ready
    add(1'b1, 8'h20, 4'hA, 1'b0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0);  // SEEK ch1 grant
    add(1'b1, 8'h20, 4'hA, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h21, 4'hA, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h22, 4'hA, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h23, 4'hA, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h24, 4'hA, 1'b0, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0);  // IDLE, done
    add(1'b1, 8'h24, 4'hA, 1'b0, 4'h0, 2'd1, 1'b1, 1'b0, 1'b0);  // SEEK ch2 not ready
    add(1'b1, 8'h24, 4'hA, 1'b0, 4'h0, 2'd1, 1'b1, 1'b0, 1'b0);  // SEEK ch3 grant
    add(1'b1, 8'h24, 4'hA, 1'b1, 4'h8, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h25, 4'hA, 1'b1, 4'h8, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h26, 4'hA, 1'b1, 4'h8, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h27, 4'hA, 1'b1, 4'h8, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 4'hA, 1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 1'b0);  // IDLE, done, ptr=0

    // Producer gaps on ch0, including a long idle gap with ch0 not ready.
    add(1'b1, 8'h30, 4'hF, 1'b0, 4'h0, 2'd3, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h30, 4'hF, 1'b0, 4'h0, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h30, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h31, 4'hF, 1'b1, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h31, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      add(1'b0, 8'h32, 4'hE, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h32, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h33, 4'hF, 1'b1, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h33, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 1'b0);  // done, ptr=1

    // Reset and idle values.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_outs("reset", mk(1'b0, 8'h00, 4'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Async reset mid-XFER on ch1 (ptr=1 after the gap burst).
    apply(mk(1'b1, 8'h50, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0), "rst.idle");
    apply(mk(1'b1, 8'h50, 4'hF, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0), "rst.seek");
    apply(mk(1'b1, 8'h50, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0), "rst.beat0");
    bus.in_data = 8'h51;
    #1;
    chk_outs("rst.pre", mk(1'b1, 8'h51, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0));
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", mk(1'b1, 8'h51, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk_outs("rst.held", mk(1'b1, 8'h51, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Abort: ch0 takes 2 beats, stalls 8 cycles, third beat goes to ch1.
    apply(mk(1'b1, 8'h40, 4'hF, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0), "ab.idle");
    apply(mk(1'b1, 8'h40, 4'hF, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0), "ab.seek");
    apply(mk(1'b1, 8'h40, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0), "ab.beat0");
    apply(mk(1'b1, 8'h41, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b0, 1'b0), "ab.beat1");
    for (int k = 0; k < 8; k++)
      apply(mk(1'b1, 8'h42, 4'hE, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b0), $sformatf("ab.stall%0d", k));
    apply(mk(1'b1, 8'h42, 4'hE, 1'b0, 4'h0, 2'd0, 1'b1, 1'b0, 1'b1), "ab.seek1");
    apply(mk(1'b1, 8'h42, 4'hE, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0), "ab.ch1b0");
    apply(mk(1'b1, 8'h43, 4'hE, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0), "ab.ch1b1");
    apply(mk(1'b1, 8'h44, 4'hE, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0), "ab.ch1b2");
    apply(mk(1'b1, 8'h45, 4'hE, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 1'b0), "ab.ch1b3");
    apply(mk(1'b0, 8'h00, 4'hE, 1'b0, 4'h0, 2'd1, 1'b0, 1'b1, 1'b0), "ab.done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux4_burst_sched.md
Name: demux4_burst_sched

Overview:
Round-robin burst scheduler for a 4-way demultiplexer. It accepts one input stream and steers bursts of BURST beats to output channels 0..3 in rotation, skipping channels that are not ready. It contains the select/control sequencing and a combinational 1-to-4 data steer; unselected outputs are driven to zero. It sits between a single producer and four consumers.

Parameters:
W, 8, data width in bits
BURST, 4, beats per burst per channel (>=1)
STALL_MAX, 8, consecutive stalled cycles before a burst is aborted (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a beat on in_data
in_ready  output  1  scheduler accepts beat this cycle
in_data  input  W  input beat
out_ready  input  4  per-channel consumer ready, bit i = channel i
out_valid  output  4  one-hot channel-valid, bit i = channel i
y0, y1, y2, y3  output  W each  channel data; in_data when that channel is valid, else 0
sel  output  2  currently granted channel (registered)
busy  output  1  high when state != IDLE
burst_done  output  1  one-cycle pulse, registered, after final beat of a burst
burst_abort  output  1  one-cycle pulse, registered, when a burst is abandoned on stall

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Reset: state=IDLE, ptr=0, sel=0, cnt=0, stall=0, burst_done=0, burst_abort=0; therefore in_ready=0, out_valid=0, y0..y3=0, busy=0.
- Internal: ptr (2b, next channel to try), cnt (clog2(BURST) bits, min 1), stall (clog2(STALL_MAX+1) bits).
- Combinational: xfer_ok = (state==XFER) & out_ready[sel]; in_ready = xfer_ok; out_valid[i] = xfer_ok & in_valid & (sel==i); y_i = out_valid[i] ? in_data : 0. A transfer (txn) = in_valid & in_ready.
- States:
  IDLE: if in_valid -> SEEK; else stay.
  SEEK: if out_ready[ptr] -> XFER, sel<=ptr, cnt<=0, stall<=0; else ptr<=ptr+1 (3 wraps to 0), stay. SEEK polls indefinitely; there is no timeout.
  XFER: on txn: stall<=0; if cnt==BURST-1 -> IDLE, ptr<=sel+1, burst_done<=1; else cnt<=cnt+1.
    If in_valid & !out_ready[sel]: stall<=stall+1; when stall==STALL_MAX-1 (STALL_MAX consecutive stalled cycles) -> SEEK, ptr<=sel+1, burst_abort<=1, cnt<=0.
    If !in_valid: hold cnt and stall (idle producer does not count as a stall).
- burst_done and burst_abort are high for exactly one cycle. They are mutually exclusive because txn requires out_ready.
- Latency: with in_valid high in IDLE at cycle 0 and the target channel ready, SEEK is entered at cycle 1, XFER at cycle 2, and the first beat is accepted in cycle 2. The minimum period between bursts to consecutive channels is BURST+2 cycles.
- Beats are never duplicated or dropped. An aborted burst delivers fewer than BURST beats, and the next beat goes to the next channel that is ready.
- sel changes only on the SEEK->XFER transition. out_valid is never set for more than one bit.
- When rst_n is asserted mid-burst, all outputs clear immediately (asynchronously). After release, operation restarts at ptr=0 with no pending state.
- With BURST=1, every txn ends the burst.

Test Plan:
- Reset: assert rst_n=0 mid-XFER -> in_ready=0, out_valid=0000, y0..y3=0, sel=0, busy=0 immediately; after release, first burst goes to channel 0.
- Rotation: out_ready=1111, in_valid held, data 0x01..0x10 -> 0x01-0x04 on y0, 0x05-0x08 on y1, 0x09-0x0C on y2, 0x0D-0x10 on y3; burst_done pulses 4 times; 2 idle cycles between bursts.
- Skip: out_ready=1010, start ptr=0 -> SEEK spends 1 cycle on ch0, grants ch1 (sel=1); the next burst skips ch2 and goes to ch3.
- Producer gaps: in_valid toggles 1/0 during XFER on ch0 -> 4 beats delivered, stall stays 0, no burst_abort, burst_done after 4th beat.
- Abort: ch0 accepts 2 beats, then out_ready[0]=0 with in_valid=1 for 8 cycles -> burst_abort pulses once, state SEEK with ptr=1; the 3rd beat is delivered on y1.
- Data isolation: during any transfer, check unselected y_i==0 and out_valid is one-hot or zero every cycle (assertion).
